mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the byte address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the data word.
REQ-003 SHALL have parameter MEM_TOP, default 32'h1FFFF: highest legal byte address of data memory.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports reqN_valid  input  1 (N=0,1): requester N has a pending access; N=0 is the CPU, N=1 is the DMA/loader.
REQ-007 SHALL have ports reqN_ready  output  1: the request is accepted this cycle.
REQ-008 SHALL have ports reqN_we  input  1: 1=store, 0=load.
REQ-009 SHALL have ports reqN_memtype  input  1: 1=byte, 0=word (4 bytes, little-endian).
REQ-010 SHALL have ports reqN_addr  input  ADDR_WIDTH: byte address.
REQ-011 SHALL have ports reqN_wdata  input  DATA_WIDTH: store data; only [7:0] is used for byte stores.
REQ-012 SHALL have ports rspN_valid  output  1: one-cycle completion pulse to requester N.
REQ-013 SHALL have ports rspN_rdata  output  DATA_WIDTH: load data; valid only while rspN_valid=1.
REQ-014 SHALL have ports rspN_err  output  1: the access was out of range; valid only while rspN_valid=1.
REQ-015 SHALL have port mem_we  output  1: write enable to data memory.
REQ-016 SHALL have port mem_memtype  output  1: byte/word select to data memory.
REQ-017 SHALL have port mem_a  output  ADDR_WIDTH: address to data memory.
REQ-018 SHALL have port mem_wd  output  DATA_WIDTH: write data to data memory.
REQ-019 SHALL have port mem_rd  input  DATA_WIDTH: combinational read data from data memory; byte loads arrive zero-extended.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any reqN_valid, ACCESS->RESP always, RESP->IDLE always.
REQ-021 SHALL choose the winner in IDLE round-robin: when both requesters are valid, grant the one not in last_grant; when one is valid, grant that one.
REQ-022 SHALL assert reqN_ready combinationally only in IDLE, and only for the winner; at most one ready is high per cycle.
REQ-023 SHALL latch we, memtype, addr, wdata and the winner ID on the cycle where valid and ready are both high.
REQ-024 SHALL flag a latched access as error when addr > MEM_TOP, or when it is a word access with addr+3 > MEM_TOP; the addr+3 compare is computed at ADDR_WIDTH+1 bits so it cannot wrap.
REQ-025 SHALL in ACCESS drive mem_a/mem_memtype/mem_wd from the latched values, and assert mem_we=1 for exactly that one cycle if the access is a store with no error.
REQ-026 SHALL in ACCESS capture mem_rd into a response register for a load with no error; otherwise it captures 0.
REQ-027 SHALL in RESP pulse rspW_valid=1 for exactly one cycle, where W is the winner, with rspW_err=error flag; stores also receive this pulse as an acknowledge.
REQ-028 SHALL update last_grant to W on the transition from RESP to IDLE.
REQ-029 SHALL hold rsp*_valid=0, mem_we=0, and mem_a/mem_wd/mem_memtype at 0 outside ACCESS/RESP as applicable; rsp*_rdata/err hold 0 when not valid.
REQ-030 SHALL have latency acceptance-to-rsp_valid = 2 cycles, and SHALL accept at most one transaction per 3 cycles.
REQ-031 SHALL ignore reqN_valid outside IDLE; requesters hold their request stable until ready.

Reset
REQ-032 SHALL on rst_n=0 immediately set state=IDLE, last_grant=1 (so requester 0 wins the first tie), and clear all latched registers and outputs to 0.
REQ-033 SHALL, if reset is asserted mid-transaction, drop the in-flight transaction: no mem_we and no rsp pulse occur after reset.

Verification
REQ-034 SHALL cover this case: a single req0 word load at 0x10000 with memory holding 0xDEADBEEF -> ready0 in cycle 0, rsp0_valid in cycle 2, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL cover this case: req0 and req1 held continuously from reset -> grants alternate 0,1,0,1, and each grant is 3 cycles apart.
REQ-036 SHALL cover this case: req1 byte store 0xA5 at 0x1FFFF -> mem_we high for 1 cycle with mem_a=0x1FFFF and mem_memtype=1, then rsp1_valid with err=0.
REQ-037 SHALL cover this case: req0 word store at 0x1FFFD -> no mem_we, and rsp0_valid with err=1; separately, a word load at 0xFFFFFFFF -> err=1 with no wrap.
REQ-038 SHALL cover this case: rst_n pulsed low during ACCESS of a store -> mem_we stays 0, no rsp pulse, and a subsequent tie grants requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory. Requester 0 is the CPU, requester 1 is the DMA/loader.
// One transaction is in flight at a time: IDLE (grant) -> ACCESS (memory
// cycle) -> RESP (completion pulse), so acceptance to response is 2 cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/ready      request handshake, N = 0 (CPU), 1 (DMA)
//   reqN_we, reqN_memtype store/load, byte/word select
//   reqN_addr, reqN_wdata byte address, store data ([7:0] for byte stores)
//   rspN_valid            one-cycle completion pulse (loads and stores)
//   rspN_rdata, rspN_err  load data and out-of-range flag, 0 when not valid
//   mem_we, mem_memtype   data memory strobes, active during ACCESS only
//   mem_a, mem_wd         data memory address / write data
//   mem_rd                combinational read data from memory
//
// state  | meaning
// IDLE   | waiting for a request; ready asserted for the round-robin winner
// ACCESS | latched request presented to memory; load data captured
// RESP   | completion pulse to the winner; last_grant updated on exit

module mem_arbiter #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] MEM_TOP    = 32'h1FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic                  req0_memtype,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic                  req1_memtype,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,

    output logic                  mem_we,
    output logic                  mem_memtype,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Range checks are done one bit wider than the address so addr+3 never wraps.
    localparam logic [ADDR_WIDTH:0] MEM_TOP_EXT = (ADDR_WIDTH+1)'(MEM_TOP);

    state_t                state;
    state_t                state_nxt;

    logic                  last_grant;
    logic                  lat_id;
    logic                  lat_we;
    logic                  lat_memtype;
    logic                  lat_err;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  sel_we;
    logic                  sel_memtype;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH:0]   addr_ext;
    logic [ADDR_WIDTH:0]   addr_end;
    logic                  sel_err;

    // Round-robin winner selection; only meaningful in IDLE.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid & ~grant_id;
    assign req1_ready = grant_valid &  grant_id;

    assign sel_we      = grant_id ? req1_we      : req0_we;
    assign sel_memtype = grant_id ? req1_memtype : req0_memtype;
    assign sel_addr    = grant_id ? req1_addr    : req0_addr;
    assign sel_wdata   = grant_id ? req1_wdata   : req0_wdata;

    assign addr_ext = {1'b0, sel_addr};
    assign addr_end = addr_ext + (ADDR_WIDTH+1)'(3);
    assign sel_err  = (addr_ext > MEM_TOP_EXT) ||
                      (!sel_memtype && (addr_end > MEM_TOP_EXT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_we      = 1'b0;
        mem_memtype = 1'b0;
        mem_a       = '0;
        mem_wd      = '0;
        rsp0_valid  = 1'b0;
        rsp0_rdata  = '0;
        rsp0_err    = 1'b0;
        rsp1_valid  = 1'b0;
        rsp1_rdata  = '0;
        rsp1_err    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt   = RESP;
                mem_a       = lat_addr;
                mem_memtype = lat_memtype;
                mem_wd      = lat_wdata;
                mem_we      = lat_we & ~lat_err;
            end
            RESP: begin
                state_nxt = IDLE;
                if (lat_id) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = rsp_data;
                    rsp1_err   = lat_err;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = rsp_data;
                    rsp0_err   = lat_err;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            lat_id      <= 1'b0;
            lat_we      <= 1'b0;
            lat_memtype <= 1'b0;
            lat_err     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rsp_data    <= '0;
        end else begin
            if (grant_valid) begin
                lat_id      <= grant_id;
                lat_we      <= sel_we;
                lat_memtype <= sel_memtype;
                lat_err     <= sel_err;
                lat_addr    <= sel_addr;
                lat_wdata   <= sel_wdata;
            end
            if (state == ACCESS) begin
                rsp_data <= (!lat_we && !lat_err) ? mem_rd : '0;
            end
            if (state == RESP) begin
                last_grant <= lat_id;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs are driven and outputs sampled around the falling clock edge.

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_memtype;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_memtype;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic        mem_we, mem_memtype;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_we      (req0_we),
        .req0_memtype (req0_memtype),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_we      (req1_we),
        .req1_memtype (req1_memtype),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .mem_we       (mem_we),
        .mem_memtype  (mem_memtype),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_reqs();
        req0_valid = 0; req0_we = 0; req0_memtype = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_memtype = 0; req1_addr = 0; req1_wdata = 0;
    endtask

    // One word load by req0; checks response two cycles after acceptance.
    task automatic load0(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_memtype = 0; req0_addr = addr;
        #1;
        chk({tag, "_ready0"}, req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk({tag, "_acc_we"}, mem_we, 0);
        @(negedge clk);
        #1;
        chk({tag, "_rsp0_valid"}, rsp0_valid, 1);
        chk({tag, "_rsp0_rdata"}, rsp0_rdata, exp_data);
        chk({tag, "_rsp0_err"}, rsp0_err, exp_err);
    endtask

    initial begin
        rst_n  = 0;
        mem_rd = 32'h0;
        clr_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_ready1", req1_ready, 0);

        // Single word load, data DEADBEEF, 2-cycle latency.
        mem_rd = 32'hDEADBEEF;
        @(negedge clk);
        req0_valid = 1; req0_addr = 32'h10000;
        #1;
        chk("ld_ready0", req0_ready, 1);
        chk("ld_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("ld_mem_a", mem_a, 32'h10000);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_rsp_early", rsp0_valid, 0);
        @(negedge clk);
        #1;
        chk("ld_rsp0_valid", rsp0_valid, 1);
        chk("ld_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
        chk("ld_rsp0_err", rsp0_err, 0);
        chk("ld_rsp1_valid", rsp1_valid, 0);
        @(negedge clk);
        #1;
        chk("ld_rsp_pulse", rsp0_valid, 0);
        chk("ld_rdata_idle", rsp0_rdata, 0);

        // req1 byte store of A5 at the top legal address.
        @(negedge clk);
        req1_valid = 1; req1_we = 1; req1_memtype = 1;
        req1_addr = 32'h1FFFF; req1_wdata = 32'h123456A5;
        #1;
        chk("bs_ready1", req1_ready, 1);
        chk("bs_ready0", req0_ready, 0);
        @(negedge clk);
        clr_reqs();
        #1;
        chk("bs_mem_we", mem_we, 1);
        chk("bs_mem_a", mem_a, 32'h1FFFF);
        chk("bs_mem_memtype", mem_memtype, 1);
        chk("bs_mem_wd", mem_wd[7:0], 8'hA5);
        @(negedge clk);
        #1;
        chk("bs_we_once", mem_we, 0);
        chk("bs_mem_a_idle", mem_a, 0);
        chk("bs_rsp1_valid", rsp1_valid, 1);
        chk("bs_rsp1_err", rsp1_err, 0);
        chk("bs_rsp0_valid", rsp0_valid, 0);

        // req0 word store straddling the top: error, no write.
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_memtype = 0;
        req0_addr = 32'h1FFFD; req0_wdata = 32'h11223344;
        #1;
        chk("ws_ready0", req0_ready, 1);
        @(negedge clk);
        clr_reqs();
        #1;
        chk("ws_mem_we", mem_we, 0);
        @(negedge clk);
        #1;
        chk("ws_rsp0_valid", rsp0_valid, 1);
        chk("ws_rsp0_err", rsp0_err, 1);
        chk("ws_mem_we2", mem_we, 0);

        // Last legal word, then a load that would wrap in 32 bits.
        mem_rd = 32'hCAFEF00D;
        load0("wl_top", 32'h1FFFC, 32'hCAFEF00D, 0);
        load0("wl_wrap", 32'hFFFFFFFF, 32'h0, 1);
        load0("wl_beyond", 32'h20000, 32'h0, 1);

        // Reset during ACCESS of a store; last_grant is 0 before reset.
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_memtype = 0;
        req0_addr = 32'h200; req0_wdata = 32'h55AA55AA;
        #1;
        chk("rs_ready0", req0_ready, 1);
        @(negedge clk);
        clr_reqs();
        rst_n = 0;
        #1;
        chk("rs_mem_we", mem_we, 0);
        chk("rs_mem_a", mem_a, 0);
        @(negedge clk);
        #1;
        chk("rs_rsp0_valid", rsp0_valid, 0);
        chk("rs_mem_we2", mem_we, 0);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("rs_rsp0_after", rsp0_valid, 0);
        chk("rs_mem_we3", mem_we, 0);
        req0_valid = 1; req0_addr = 32'h40;
        req1_valid = 1; req1_addr = 32'h80;
        #1;
        chk("rs_tie_ready0", req0_ready, 1);
        chk("rs_tie_ready1", req1_ready, 0);
        @(negedge clk);
        clr_reqs();
        repeat (3) @(negedge clk);

        // Both requesters held from reset: grants alternate every 3 cycles.
        rst_n = 0;
        req0_valid = 1; req0_addr = 32'h100;
        req1_valid = 1; req1_addr = 32'h104;
        mem_rd = 32'h0BADF00D;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("rr_ready0_c%0d", c), req0_ready, (c % 6) == 0);
            chk($sformatf("rr_ready1_c%0d", c), req1_ready, (c % 6) == 3);
            chk($sformatf("rr_rsp0_c%0d", c), rsp0_valid, (c % 6) == 2);
            chk($sformatf("rr_rsp1_c%0d", c), rsp1_valid, (c % 6) == 5);
        end
        clr_reqs();
        repeat (2) @(negedge clk);
        #1;
        chk("rr_idle_ready0", req0_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
